// File: rtl/pipe_exe_unit_pkg.sv
// Shared types and constants for the execute stage: ALU opcodes, multiply FSM states, E/M record.
// Pure declarations; no logic, no latency.
package pipe_exe_unit_pkg;

   localparam int         MUL_CYCLES_DEF = 32;
   localparam logic [4:0] REG_RA         = 5'd31;

   // Bit 3 only distinguishes the shift group; for the others it is a don't-care.
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } mul_state_t;

   typedef struct packed {
      logic        wreg;
      logic        m2reg;
      logic        wmem;
      logic [31:0] alu;
      logic [31:0] b;
      logic [4:0]  rn;
   } em_t;

endpackage

// File: rtl/pipe_exe_unit_if.sv
// E-stage inputs from the D/E register and E/M register outputs, bundled for the execute unit.
// The master side drives the E-stage controls/operands; the slave side is the execute unit.
interface pipe_exe_unit_if;
   logic        ewreg;
   logic        em2reg;
   logic        ewmem;
   logic [3:0]  ealuc;
   logic        ealuimm;
   logic        eshift;
   logic        ejal;
   logic        emul;
   logic [31:0] ea;
   logic [31:0] eb;
   logic [31:0] eimm;
   logic [31:0] epc4;
   logic [4:0]  ern0;
   logic [4:0]  ern;
   logic        estall;
   logic        mwreg;
   logic        mm2reg;
   logic        mwmem;
   logic [31:0] malu;
   logic [31:0] mb;
   logic [4:0]  mrn;

   modport master (
      output ewreg, em2reg, ewmem, ealuc, ealuimm, eshift, ejal, emul,
             ea, eb, eimm, epc4, ern0,
      input  ern, estall, mwreg, mm2reg, mwmem, malu, mb, mrn
   );

   modport slave (
      input  ewreg, em2reg, ewmem, ealuc, ealuimm, eshift, ejal, emul,
             ea, eb, eimm, epc4, ern0,
      output ern, estall, mwreg, mm2reg, mwmem, malu, mb, mrn
   );
endinterface

// File: rtl/pipe_exe_unit_alu.sv
// Combinational 32-bit ALU (wrapping arithmetic, no overflow trap).
// Zero latency; no flow control.
module pipe_exe_unit_alu
   import pipe_exe_unit_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  aluc,
   output logic [31:0] r
);

   always_comb begin
      r = '0;
      if (aluc[1:0] == 2'b11) begin
         case (aluc)
            ALU_SLL: r = b << a[4:0];
            ALU_SRL: r = b >> a[4:0];
            ALU_SRA: r = $signed(b) >>> a[4:0];
            default: r = '0;
         endcase
      end else begin
         case (aluc[2:0])
            ALU_ADD[2:0]: r = a + b;
            ALU_SUB[2:0]: r = a - b;
            ALU_AND[2:0]: r = a & b;
            ALU_OR[2:0]:  r = a | b;
            ALU_XOR[2:0]: r = a ^ b;
            ALU_LUI[2:0]: r = {b[15:0], 16'h0000};
            default:      r = '0;
         endcase
      end
   end

endmodule

// File: rtl/pipe_exe_unit.sv
// Execute stage: operand select, ALU / iterative shift-add multiply, jal link, E/M register.
// ALU ops: 1 cycle; multiply: 34 cycles with estall held for 33, E/M receives bubbles meanwhile.
module pipe_exe_unit
   import pipe_exe_unit_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
   input  logic           clock,
   input  logic           resetn,
   pipe_exe_unit_if.slave bus
);

   localparam int            CW   = $clog2(MUL_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

   logic [31:0]   op_a;
   logic [31:0]   op_b;
   logic [31:0]   alu_r;
   logic [31:0]   result;
   logic [31:0]   mcand;
   logic [31:0]   mplier;
   logic [31:0]   product;
   logic [CW-1:0] count;
   mul_state_t    state;
   mul_state_t    state_nxt;
   logic          mul_start;
   logic          mul_load;
   logic          mul_step;
   logic          use_product;
   logic          stall;
   em_t           em_d;
   em_t           em_q;

   assign op_a      = bus.eshift  ? {27'b0, bus.eimm[10:6]} : bus.ea;
   assign op_b      = bus.ealuimm ? bus.eimm : bus.eb;
   assign bus.ern   = bus.ejal    ? REG_RA : bus.ern0;
   // jal takes priority over a multiply request in the same instruction.
   assign mul_start = bus.emul && !bus.ejal;

   pipe_exe_unit_alu u_alu (
      .a    (op_a),
      .b    (op_b),
      .aluc (bus.ealuc),
      .r    (alu_r)
   );

   always_ff @(posedge clock) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (mul_start) state_nxt = ST_MUL;
         ST_MUL:  if (count == LAST) state_nxt = ST_DONE;
         // emul is still asserted while the product drains; never restart from here.
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      mul_load    = (state == ST_IDLE) && mul_start;
      mul_step    = (state == ST_MUL);
      use_product = (state == ST_DONE);
      stall       = mul_load || mul_step;
   end

   assign bus.estall = stall;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
         count   <= '0;
      end else if (mul_load) begin
         mcand   <= op_a;
         mplier  <= op_b;
         product <= '0;
         count   <= '0;
      end else if (mul_step) begin
         if (mplier[0]) product <= product + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + CW'(1);
      end
   end

   assign result = bus.ejal ? bus.epc4 + 32'd4 : (use_product ? product : alu_r);

   always_comb begin
      em_d = '0;
      if (!stall) begin
         em_d.wreg  = bus.ewreg;
         em_d.m2reg = bus.em2reg;
         em_d.wmem  = bus.ewmem;
         em_d.alu   = result;
         em_d.b     = bus.eb;
         em_d.rn    = bus.ern;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) em_q <= '0;
      else         em_q <= em_d;
   end

   assign bus.mwreg  = em_q.wreg;
   assign bus.mm2reg = em_q.m2reg;
   assign bus.mwmem  = em_q.wmem;
   assign bus.malu   = em_q.alu;
   assign bus.mb     = em_q.b;
   assign bus.mrn    = em_q.rn;

endmodule
